// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared widths and encodings for the CPU memory-port arbiter.
package cpu_bus_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshakes of the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = cpu_bus_pkg::DEF_ADDR_W,
    parameter int DATA_W = cpu_bus_pkg::DEF_DATA_W
);
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [DATA_W-1:0]   if_rdata;
    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_be;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [DATA_W-1:0]   d_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
               mem_ack, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
               mem_ack, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_select.sv
// mem_arb_select: D-priority winner selection with a streak counter that
// forces an IF grant after MAX_D_STREAK back-to-back D grants over a waiting IF.
module mem_arb_select #(
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic win_d,
    output logic win_if
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] MAX = SW'(MAX_D_STREAK);
    logic [SW-1:0] streak;
    assign win_d  = d_req && !(if_req && streak == MAX);
    assign win_if = if_req && !win_d;
    // A D win over a waiting IF implies streak < MAX, so the increment saturates by construction.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            streak <= '0;
        else if (grant_en && win_d && if_req)
            streak <= streak + 1'b1;
        else if (grant_en && (win_d || win_if))
            streak <= '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store, one transaction outstanding, D priority with IF anti-starvation.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = 3
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    logic [1:0]        state;
    logic              owner;
    logic              l_we;
    logic [BE_W-1:0]   l_be;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              if_gnt_q, d_gnt_q, if_rv_q, d_rv_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              idle, win_d, win_if;
    assign idle = state == S_IDLE;
    mem_arb_select #(.MAX_D_STREAK(MAX_D_STREAK)) u_sel (
        .clk     (clk),
        .reset   (reset),
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .grant_en(idle),
        .win_d   (win_d),
        .win_if  (win_if)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            l_we       <= 1'b0;
            l_be       <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_rv_q    <= 1'b0;
            d_rv_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_gnt_q   <= idle && win_if;
            d_gnt_q    <= idle && win_d;
            if_rv_q    <= 1'b0;
            d_rv_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if (idle && (win_d || win_if)) begin
                state   <= S_ISSUE;
                owner   <= win_d ? OWN_D : OWN_IF;
                l_we    <= win_d && bus.d_we;
                l_be    <= win_d ? bus.d_be : '1;
                l_addr  <= win_d ? bus.d_addr : bus.if_addr;
                l_wdata <= win_d ? bus.d_wdata : '0;
            end else if (state == S_ISSUE && bus.mem_ack) begin
                state <= S_RESP;
            end else if (state == S_RESP && bus.mem_rvalid) begin
                state      <= S_IDLE;
                if_rv_q    <= owner == OWN_IF;
                d_rv_q     <= owner == OWN_D;
                if_rdata_q <= owner == OWN_IF ? bus.mem_rdata : '0;
                d_rdata_q  <= (owner == OWN_D && !l_we) ? bus.mem_rdata : '0;
            end
        end
    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rv_q;
    assign bus.d_rvalid  = d_rv_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = state == S_ISSUE;
    assign bus.mem_we    = l_we;
    assign bus.mem_be    = l_be;
    assign bus.mem_addr  = l_addr;
    assign bus.mem_wdata = l_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and a random run
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int MAX = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    mem_port_arbiter_if bus ();
    mem_port_arbiter #(.MAX_D_STREAK(MAX)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic ireq, dreq, we;
        logic [3:0] be;
        logic [31:0] iaddr, daddr, wdata, mrdata;
        logic exp_d;
    } vec_t;
    vec_t vecs[11];

    function automatic vec_t mk(logic ir, logic dr, logic we, logic [3:0] be, logic [31:0] ia,
                                logic [31:0] da, logic [31:0] wd, logic [31:0] rd, logic ed);
        vec_t v;
        v.ireq = ir; v.dreq = dr; v.we = we; v.be = be; v.iaddr = ia;
        v.daddr = da; v.wdata = wd; v.mrdata = rd; v.exp_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.if_gnt || bus.d_gnt) && t < 20);
    endtask

    task automatic complete(input logic is_d, input logic we, input logic [31:0] rd);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("mem_req_drop", bus.mem_req, 0);
        chk("gnt_pulse", bus.if_gnt | bus.d_gnt, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("if_rvalid", bus.if_rvalid, !is_d);
        chk("d_rvalid", bus.d_rvalid, is_d);
        chk(is_d ? "d_rdata" : "if_rdata", is_d ? bus.d_rdata : bus.if_rdata, (is_d && we) ? 32'h0 : rd);
    endtask

    task automatic txn(input vec_t v);
        bus.if_req = v.ireq; bus.if_addr = v.iaddr;
        bus.d_req = v.dreq; bus.d_we = v.we; bus.d_be = v.be;
        bus.d_addr = v.daddr; bus.d_wdata = v.wdata;
        wait_gnt();
        chk("d_gnt", bus.d_gnt, v.exp_d);
        chk("if_gnt", bus.if_gnt, !v.exp_d);
        chk("mem_req", bus.mem_req, 1);
        chk("mem_addr", bus.mem_addr, v.exp_d ? v.daddr : v.iaddr);
        chk("mem_we", bus.mem_we, v.exp_d & v.we);
        if (v.exp_d) begin
            chk("mem_be", bus.mem_be, v.be);
            chk("mem_wdata", bus.mem_wdata, v.wdata);
            bus.d_req = 1'b0;
        end else
            bus.if_req = 1'b0;
        complete(v.exp_d, v.we, v.mrdata);
    endtask

    task automatic random_phase();
        int streak = 0;
        bit idle = 1, acked = 0, ack_drv = 0, rv_drv = 0, own_d = 0;
        bit ir = 0, dr = 0, eg_d, eg_if, emreq;
        logic exp_we = 0;
        logic [3:0] exp_be = 0;
        logic [31:0] exp_addr = 0, exp_wdata = 0, rd_drv = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            eg_d = 0; eg_if = 0;
            if (ack_drv && !idle) acked = 1;
            if (idle && (ir || dr)) begin
                eg_d = dr && !(ir && streak == MAX);
                eg_if = !eg_d;
                streak = (eg_d && ir) ? ((streak < MAX) ? streak + 1 : MAX) : 0;
                own_d = eg_d;
                exp_we = eg_d && bus.d_we;
                exp_be = eg_d ? bus.d_be : 4'hF;
                exp_addr = eg_d ? bus.d_addr : bus.if_addr;
                exp_wdata = eg_d ? bus.d_wdata : 32'h0;
                idle = 0; acked = 0;
            end
            chk("rnd_if_rvalid", bus.if_rvalid, rv_drv && !own_d);
            chk("rnd_d_rvalid", bus.d_rvalid, rv_drv && own_d);
            if (rv_drv) begin
                chk("rnd_rdata", own_d ? bus.d_rdata : bus.if_rdata, (own_d && exp_we) ? 32'h0 : rd_drv);
                idle = 1;
            end
            emreq = !idle && !acked;
            chk("rnd_gnt", {bus.if_gnt, bus.d_gnt}, {eg_if, eg_d});
            chk("rnd_mem_req", bus.mem_req, emreq);
            if (emreq) begin
                chk("rnd_mem_addr", bus.mem_addr, exp_addr);
                chk("rnd_mem_ctl", {bus.mem_we, bus.mem_be, bus.mem_wdata}, {exp_we, exp_be, exp_wdata});
            end
            if (eg_d) dr = 0;
            if (eg_if) ir = 0;
            if (!dr && $urandom_range(2) == 0) begin
                dr = 1;
                bus.d_we = 1'($urandom_range(1));
                bus.d_be = 4'($urandom);
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
            end
            if (!ir && $urandom_range(2) == 0) begin
                ir = 1;
                bus.if_addr = $urandom;
            end
            bus.d_req = dr;
            bus.if_req = ir;
            ack_drv = emreq && $urandom_range(2) == 0;
            bus.mem_ack = ack_drv;
            rv_drv = acked && !idle && $urandom_range(1) == 0;
            rd_drv = $urandom;
            bus.mem_rdata = rd_drv;
            // stray responses while idle or issuing must be ignored
            bus.mem_rvalid = rv_drv || ((idle || emreq) && $urandom_range(3) == 0);
        end
        bus.if_req = 0; bus.d_req = 0; bus.mem_ack = 0; bus.mem_rvalid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 0, 0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h8C010004, 0);
        vecs[1] = mk(0, 1, 1, 4'hF, 32'h0, 32'h2000, 32'h12345678, 32'hFFFFFFFF, 1);
        vecs[2] = mk(0, 1, 0, 4'h3, 32'h0, 32'h3004, 32'h0, 32'hCAFEF00D, 1);
        for (int i = 0; i < 8; i++)
            vecs[3 + i] = mk(1, 1, 1'(i % 2), 4'hF, 32'h400, 32'h5000 + 32'(4 * i),
                             32'(i * 32'h111), 32'hA0000000 + 32'(i), (i % 4) != 3);
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h80; bus.d_wdata = 32'h0;
        bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {bus.if_gnt, bus.d_gnt}, 0);
        chk("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
        chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        chk("rst_mem_ctl", {bus.mem_req, bus.mem_we, bus.mem_be}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1;
        @(negedge clk);
        chk("first_d_gnt", bus.d_gnt, 1);
        chk("first_if_gnt", bus.if_gnt, 0);
        reset = 0;
        #1;
        chk("rst_issue_mem_req", bus.mem_req, 0);
        chk("rst_issue_gnt", bus.d_gnt, 0);
        bus.if_req = 0; bus.d_req = 0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 11; i++) txn(vecs[i]);
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'h3; bus.d_addr = 32'h6000; bus.d_wdata = 32'h55;
        wait_gnt();
        chk("bp_d_gnt", bus.d_gnt, 1);
        bus.d_req = 0; bus.if_req = 1; bus.if_addr = 32'h700;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_mem_req", bus.mem_req, 1);
            chk("bp_mem_addr", bus.mem_addr, 32'h6000);
            chk("bp_mem_ctl", {bus.mem_we, bus.mem_be, bus.mem_wdata}, {1'b0, 4'h3, 32'h55});
            chk("bp_if_gnt", bus.if_gnt, 0);
        end
        complete(1, 0, 32'h0BADF00D);
        @(negedge clk);
        chk("bp_if_gnt_after", bus.if_gnt, 1);
        chk("bp_if_addr", bus.mem_addr, 32'h700);
        bus.if_req = 0;
        complete(0, 0, 32'h11112222);
        bus.d_req = 1; bus.d_addr = 32'h7000; bus.d_we = 0;
        wait_gnt();
        chk("mr_d_gnt", bus.d_gnt, 1);
        bus.d_req = 0; bus.mem_ack = 1;
        @(negedge clk);
        bus.mem_ack = 0;
        reset = 0;
        #1;
        chk("mr_mem_req", bus.mem_req, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.mem_rvalid = 0;
        chk("mr_stale_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
        chk("mr_stale_rdata", bus.d_rdata, 0);
        txn(mk(1, 0, 0, 4'h0, 32'h104, 32'h0, 32'h0, 32'h24020001, 0));
        random_phase();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-ported memory between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Each side uses a req/gnt/rvalid handshake. Only one transaction is outstanding at a time.
- D has priority over IF. A streak counter guarantees IF forward progress.
- Sits between the CPU pipeline and the memory/IO block that backs SW/LED.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 3, consecutive D grants allowed while IF is waiting before IF is forced (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle accept pulse.
- if_rvalid  out  1  one-cycle fetch response.
- if_rdata  out  DATA_W  fetch data, valid with if_rvalid.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = write.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle accept pulse.
- d_rvalid  out  1  one-cycle completion (reads and writes).
- d_rdata  out  DATA_W  read data; 0 for writes.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  memory response; arrives ≥1 cycle after mem_ack.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Owner register: IF or D.
- IDLE:
  - If any req is seen at edge N, pick the winner, latch its fields, set owner, go to ISSUE.
  - Winner's gnt is registered high for cycle N+1 only.
- Arbitration:
  - Only one requesting → it wins.
  - Both requesting → D wins, unless streak == MAX_D_STREAK, in which case IF wins.
- Streak counter:
  - +1 on each D grant made while if_req = 1.
  - Cleared on any IF grant, and on a D grant made while if_req = 0.
  - Saturates at MAX_D_STREAK.
- ISSUE:
  - mem_req = 1; mem_* driven from latched regs (stable for the whole state; mem_we = 0 for IF).
  - On mem_ack → RESP. mem_req drops the cycle after the ack edge.
  - mem_rvalid in ISSUE is ignored.
- RESP:
  - On mem_rvalid, the owner's rvalid is registered high for exactly one cycle, with rdata = mem_rdata (d_rdata = 0 if the latched we = 1). FSM → IDLE.
- Latency and throughput:
  - Minimum latency, req to rvalid: 4 cycles (gnt N+1, ack N+1, mem_rvalid N+2, rvalid N+3).
  - Minimum issue interval: 4 cycles.
- Requests and gnt:
  - A req arriving outside IDLE waits; no gnt is issued until IDLE.
  - A req dropped before gnt is a protocol violation; the arbiter uses the value sampled at the IDLE edge.
  - if_gnt and d_gnt are never high together.
- Reset (reset = 0):
  - Immediately: all outputs 0, FSM IDLE, owner IF, streak 0, latched regs 0.
  - Reset mid-ISSUE/RESP abandons the transaction. A stale mem_rvalid arriving in IDLE is ignored.
- Widths:
  - DATA_W/8 must be integral.
  - Streak counter width = $clog2(MAX_D_STREAK+1).

Decomposition:
- Package cpu_bus_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE/ISSUE/RESP), owner encoding (OWN_IF/OWN_D).
- Sub-module mem_arb_select: combinational winner selection plus the streak counter register (clk/reset, if_req, d_req, grant_en → win_d, win_if).
- The top level holds the FSM, latches and response registers.

Test Plan:
- Reset: hold reset = 0 with if_req = d_req = 1 → all outputs 0, no gnt. Release → first gnt is d_gnt one cycle later.
- Single fetch: if_req = 1, if_addr = 0x100; mem_ack in the grant cycle; mem_rvalid 2 cycles later with 0x8C010004 → one if_gnt pulse, mem_addr = 0x100, mem_we = 0, if_rvalid one cycle after mem_rvalid with if_rdata = 0x8C010004, d_rvalid = 0.
- Starvation: if_req and d_req held high, MAX_D_STREAK = 3, mem answers every transaction → grant order D,D,D,IF,D,D,D,IF.
- Write: d_we = 1, d_be = 0xF, d_addr = 0x2000, d_wdata = 0x12345678 → mem_we = 1, mem_be = 0xF, fields match; d_rvalid pulse with d_rdata = 0 although mem_rdata = 0xFFFFFFFF.
- Backpressure: mem_ack low for 5 cycles → mem_req and mem_* stable throughout; a new if_req gets no gnt until the D transaction completes.
- Reset mid-RESP: reset = 0 for 2 cycles while waiting; mem_rvalid arrives after release → no rvalid output; a following if_req at 0x104 is served normally.
